md_issue_ctrl: RTL and testbench
================================

Name: md_issue_ctrl

Overview:
- Pipeline-side initiator for the multiply/divide engine; the other end of the engine's start/complete handshake.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from the execute stage and launches engine operations with a one-cycle start pulse.
- Waits for the engine's done, writes results into the architectural HI/LO registers it owns, and raises stall only on HI/LO hazards.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- TIMEOUT, 64, max cycles in WAIT before abort; counter width = $clog2(TIMEOUT+1).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- op_valid  input  1  execute stage presents an MD-class op; held stable while stall=1.
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
- rs_data  input  WIDTH  operand A / MT source.
- rt_data  input  WIDTH  operand B.
- stall  output  1  freeze execute stage; op accepted when op_valid && !stall.
- mf_data  output  WIDTH  MFHI/MFLO result, valid when accepted.
- eng_start  output  1  one-cycle launch pulse.
- eng_op  output  2  0 mult, 1 multu, 2 div, 3 divu.
- eng_a  output  WIDTH  latched operand A.
- eng_b  output  WIDTH  latched operand B.
- eng_done  input  1  engine result valid, single-cycle pulse.
- eng_hi  input  WIDTH  engine HI (remainder for div).
- eng_lo  input  WIDTH  engine LO (quotient for div).
- busy  output  1  state != IDLE.
- timeout_err  output  1  sticky abort flag.

Behaviour:
- Reset (async, reset=0): state IDLE, HI=LO=0, eng_start=0, eng_op=0, eng_a=eng_b=0, cycle counter 0, timeout_err=0; all outputs low/zero. Reset mid-operation aborts silently; a later eng_done is ignored.
- FSM IDLE -> START -> WAIT -> IDLE.
  - IDLE: accepted op 0-3 with rt_data!=0 (or op 0/1 any rt) latches eng_op/eng_a/eng_b and moves to START.
  - START: eng_start=1 for exactly this one cycle, then WAIT; counter cleared.
  - WAIT: counter increments each cycle.
    - eng_done=1: HI<=eng_hi, LO<=eng_lo at that edge, then IDLE.
    - counter reaches TIMEOUT without done: IDLE, HI/LO unchanged, timeout_err<=1.
- Launch latency: accept edge -> eng_start high next cycle. Minimum op-to-IDLE is 3 cycles when done arrives on the first WAIT cycle.
- Divide by zero (op 2/3, rt_data=0): accepted, no launch, HI/LO unchanged, state stays IDLE, no stall.
- Stall (combinational):
  - stall = op_valid && busy && op in {0..7}.
  - Any MD-class op while busy stalls. Non-MD instructions proceed because op_valid=0.
- MTHI/MTLO in IDLE: HI (resp. LO) <= rs_data at accept edge.
- MFHI/MFLO in IDLE: mf_data = HI/LO combinationally. Otherwise mf_data=0.
- eng_done in IDLE or START is ignored and does not change HI/LO.
- busy drops the cycle after the done edge. MF stalled on done cycle reads new value next cycle; no forwarding path.
- Signed/unsigned semantics are the engine's. This block never inspects eng_hi/eng_lo.

Decomposition:
- Shared package md_pkg: op encodings (MD_MULT..MD_MFLO), engine op encodings, state enum {IDLE,START,WAIT}.
- No sub-module: the HI/LO pair and FSM stay in one module. An optional behavioural engine model md_engine_bfm (parameterised latency) lives in the testbench only.

Test Plan:
- MULT rs=0xFFFFFFFE, rt=3, BFM latency 4 -> eng_start 1 cycle after accept, eng_op=0; HI=0xFFFFFFFF, LO=0xFFFFFFFA after done; busy low next cycle.
- DIVU rs=100, rt=7, followed immediately by MFLO -> MFLO stalls until busy=0, then mf_data=14; MFHI then returns 2.
- DIV rt=0 with HI=5, LO=9 preset via MTHI/MTLO -> no eng_start, no stall, HI=5, LO=9 unchanged.
- BFM never asserts done, TIMEOUT=64 -> IDLE after 64 WAIT cycles, timeout_err=1, HI/LO unchanged.
- reset=0 pulse during WAIT, then stray eng_done -> HI=LO=0, state IDLE, no write from stray done.
- Back-to-back MULTU 0xFFFFFFFF*0xFFFFFFFF then MTHI 0x1234 -> MTHI stalls until first completes; final HI=0x1234, LO=0x00000001.

Source files
------------

// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide issue controller: pipeline op codes,
// engine op codes and controller FSM states.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_MFHI  = 3'd6,
    MD_MFLO  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ENG_MULT  = 2'd0,
    ENG_MULTU = 2'd1,
    ENG_DIV   = 2'd2,
    ENG_DIVU  = 2'd3
  } eng_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } md_state_e;

  // Divides by zero are swallowed without an engine launch.
  function automatic logic launches(input md_op_e op, input logic rt_nonzero);
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (((op == MD_DIV) || (op == MD_DIVU)) && rt_nonzero);
  endfunction

endpackage

// File: rtl/md_issue_ctrl.sv
// Pipeline-side initiator for the multiply/divide engine: launches operations,
// owns the architectural HI/LO pair and stalls MD-class ops while busy.
import md_pkg::*;

module md_issue_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             stall,
  output logic [WIDTH-1:0] mf_data,
  output logic             eng_start,
  output logic [1:0]       eng_op,
  output logic [WIDTH-1:0] eng_a,
  output logic [WIDTH-1:0] eng_b,
  input  logic             eng_done,
  input  logic [WIDTH-1:0] eng_hi,
  input  logic [WIDTH-1:0] eng_lo,
  output logic             busy,
  output logic             timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  md_state_e        state;
  md_op_e           op_e;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             accept;

  assign op_e     = md_op_e'(op);
  assign busy     = (state != IDLE);
  // Every 3-bit op is MD-class, so any valid op stalls while busy.
  assign stall    = op_valid && busy;
  assign accept   = op_valid && !busy;
  assign cnt_next = cnt + CNT_W'(1);

  always_comb begin
    mf_data = '0;
    if (accept && op_e == MD_MFHI) begin
      mf_data = hi;
    end else if (accept && op_e == MD_MFLO) begin
      mf_data = lo;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      hi          <= '0;
      lo          <= '0;
      cnt         <= '0;
      eng_start   <= 1'b0;
      eng_op      <= '0;
      eng_a       <= '0;
      eng_b       <= '0;
      timeout_err <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (launches(op_e, |rt_data)) begin
              state     <= START;
              eng_start <= 1'b1;
              eng_op    <= eng_op_e'(op[1:0]);
              eng_a     <= rs_data;
              eng_b     <= rt_data;
            end else if (op_e == MD_MTHI) begin
              hi <= rs_data;
            end else if (op_e == MD_MTLO) begin
              lo <= rs_data;
            end
          end
        end
        START: begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT: begin
          if (eng_done) begin
            hi    <= eng_hi;
            lo    <= eng_lo;
            state <= IDLE;
          end else if (cnt_next == CNT_W'(TIMEOUT)) begin
            cnt         <= cnt_next;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl with an in-bench engine model of adjustable latency.
import md_pkg::*;

module tb_md_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        stall;
  logic [31:0] mf_data;
  logic        eng_start;
  logic [1:0]  eng_op;
  logic [31:0] eng_a, eng_b;
  logic        eng_done;
  logic [31:0] eng_hi = '0;
  logic [31:0] eng_lo = '0;
  logic        busy, timeout_err;

  logic        bfm_done = 1'b0;
  logic        stray_done = 1'b0;
  bit          bfm_en = 1'b1;
  int unsigned lat = 4;
  int unsigned pend_cnt = 0;
  bit          pend = 1'b0;

  int checks = 0;
  int failures = 0;

  assign eng_done = bfm_done | stray_done;

  always #5 clk = ~clk;

  md_issue_ctrl #(.WIDTH(32), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .mf_data(mf_data),
    .eng_start(eng_start), .eng_op(eng_op), .eng_a(eng_a), .eng_b(eng_b),
    .eng_done(eng_done), .eng_hi(eng_hi), .eng_lo(eng_lo),
    .busy(busy), .timeout_err(timeout_err)
  );

  // Engine model: done pulses `lat` cycles after the start cycle.
  always @(negedge clk or negedge reset) begin
    longint          sp;
    longint unsigned up;
    int              sa, sb;
    if (!reset) begin
      pend     = 1'b0;
      bfm_done = 1'b0;
    end else begin
      bfm_done = 1'b0;
      if (pend) begin
        if (pend_cnt == 1) begin
          bfm_done = 1'b1;
          pend     = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      if (eng_start && bfm_en) begin
        pend     = 1'b1;
        pend_cnt = lat;
        case (eng_op)
          2'd0: begin
            sa = eng_a; sb = eng_b; sp = longint'(sa) * longint'(sb);
            eng_hi = sp[63:32]; eng_lo = sp[31:0];
          end
          2'd1: begin
            up = longint'({32'd0, eng_a}) * longint'({32'd0, eng_b});
            eng_hi = up[63:32]; eng_lo = up[31:0];
          end
          2'd2: begin
            sa = eng_a; sb = eng_b;
            eng_hi = sa % sb; eng_lo = sa / sb;
          end
          default: begin
            eng_hi = eng_a % eng_b; eng_lo = eng_a / eng_b;
          end
        endcase
      end
    end
  end

  task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1; op = o; rs_data = a; rt_data = b;
  endtask

  task automatic idle_in();
    op_valid = 1'b0; op = 3'd0; rs_data = '0; rt_data = '0;
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    @(negedge clk);
    drive(MD_MFHI, '0, '0);
    #1 h = mf_data;
    drive(MD_MFLO, '0, '0);
    #1 l = mf_data;
    idle_in();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_in();
    repeat (3) @(negedge clk);
    drive(MD_MFHI, '0, '0);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (eng_start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", eng_start); end
    checks++; if ({eng_op, eng_a, eng_b} !== '0) begin failures++; $display("FAIL reset_eng got=%h exp=0", {eng_op, eng_a, eng_b}); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_tmo got=%b exp=0", timeout_err); end
    checks++; if (mf_data !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", mf_data); end
    idle_in();
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_mult();
    int n;
    logic [31:0] h, l;
    lat = 4; bfm_en = 1'b1;
    @(negedge clk) drive(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mult_stall got=%b exp=0", stall); end
    @(negedge clk) idle_in();
    checks++; if (eng_start !== 1'b1) begin failures++; $display("FAIL mult_start got=%b exp=1", eng_start); end
    checks++; if (eng_op !== 2'd0) begin failures++; $display("FAIL mult_engop got=%0d exp=0", eng_op); end
    checks++; if (eng_a !== 32'hFFFF_FFFE || eng_b !== 32'd3) begin failures++; $display("FAIL mult_opnd got=%h/%h exp=fffffffe/3", eng_a, eng_b); end
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        checks++; if (eng_start !== 1'b0) begin failures++; $display("FAIL mult_pulse got=%b exp=0", eng_start); end
      end
    end
    checks++; if (n != 5) begin failures++; $display("FAIL mult_latency got=%0d exp=5", n); end
    read_hilo(h, l);
    checks++; if (h !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", h); end
    checks++; if (l !== 32'hFFFF_FFFA) begin failures++; $display("FAIL mult_lo got=%h exp=fffffffa", l); end
  endtask

  task automatic test_divu_mflo();
    int n;
    lat = 2; bfm_en = 1'b1;
    @(negedge clk) drive(MD_DIVU, 32'd100, 32'd7);
    @(negedge clk) drive(MD_MFLO, '0, '0);
    n = 0;
    while (n < 20) begin
      #1;
      if (!stall) break;
      if (mf_data !== 32'h0) begin
        checks++; failures++; $display("FAIL divu_mf_stalled got=%h exp=0", mf_data);
      end
      n++;
      @(negedge clk);
    end
    checks++; if (n != 3) begin failures++; $display("FAIL divu_stall_cycles got=%0d exp=3", n); end
    checks++; if (mf_data !== 32'd14) begin failures++; $display("FAIL divu_mflo got=%0d exp=14", mf_data); end
    drive(MD_MFHI, '0, '0);
    #1;
    checks++; if (mf_data !== 32'd2) begin failures++; $display("FAIL divu_mfhi got=%0d exp=2", mf_data); end
    @(negedge clk) idle_in();
  endtask

  task automatic test_div_zero();
    logic [31:0] h, l;
    @(negedge clk) drive(MD_MTHI, 32'd5, '0);
    @(negedge clk) drive(MD_MTLO, 32'd9, '0);
    @(negedge clk) drive(MD_DIV, 32'd50, 32'd0);
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL dz_stall got=%b exp=0", stall); end
    @(negedge clk) idle_in();
    checks++; if (eng_start !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL dz_launch got=%b%b exp=00", eng_start, busy); end
    read_hilo(h, l);
    checks++; if (h !== 32'd5 || l !== 32'd9) begin failures++; $display("FAIL dz_hilo got=%0d/%0d exp=5/9", h, l); end
  endtask

  task automatic test_timeout();
    int n;
    logic [31:0] h, l;
    bfm_en = 1'b0;
    @(negedge clk) drive(MD_MULT, 32'd7, 32'd9);
    @(negedge clk) idle_in();
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL tmo_early got=%b exp=0", timeout_err); end
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n != 65) begin failures++; $display("FAIL tmo_cycles got=%0d exp=65", n); end
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL tmo_flag got=%b exp=1", timeout_err); end
    read_hilo(h, l);
    checks++; if (h !== 32'd5 || l !== 32'd9) begin failures++; $display("FAIL tmo_hilo got=%0d/%0d exp=5/9", h, l); end
    bfm_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] h, l;
    lat = 10; bfm_en = 1'b1;
    @(negedge clk) drive(MD_MULT, 32'd3, 32'd4);
    @(negedge clk) idle_in();
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rm_busy_pre got=%b exp=1", busy); end
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin failures++; $display("FAIL rm_async got=%b%b exp=00", busy, timeout_err); end
    checks++; if (eng_a !== 32'h0 || eng_b !== 32'h0) begin failures++; $display("FAIL rm_eng got=%h/%h exp=0/0", eng_a, eng_b); end
    @(negedge clk) reset = 1'b1;
    @(negedge clk) stray_done = 1'b1;
    @(negedge clk) stray_done = 1'b0;
    checks++; if (busy !== 1'b0 || eng_start !== 1'b0) begin failures++; $display("FAIL rm_stray_fsm got=%b%b exp=00", busy, eng_start); end
    read_hilo(h, l);
    checks++; if (h !== 32'h0 || l !== 32'h0) begin failures++; $display("FAIL rm_hilo got=%h/%h exp=0/0", h, l); end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [31:0] h, l;
    lat = 3; bfm_en = 1'b1;
    @(negedge clk) drive(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk) drive(MD_MTHI, 32'h1234, '0);
    n = 0;
    while (n < 20) begin
      #1;
      if (!stall) break;
      n++;
      @(negedge clk);
    end
    checks++; if (n != 4) begin failures++; $display("FAIL b2b_stall_cycles got=%0d exp=4", n); end
    @(negedge clk) idle_in();
    read_hilo(h, l);
    checks++; if (h !== 32'h1234) begin failures++; $display("FAIL b2b_hi got=%h exp=1234", h); end
    checks++; if (l !== 32'h1) begin failures++; $display("FAIL b2b_lo got=%h exp=1", l); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_divu_mflo();
    test_div_zero();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
